// File: rtl/parking_pkg.sv
// Shared types and default sizing for the car-park entry gate.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'b00,
        ST_OPENING = 2'b01,
        ST_OPEN    = 2'b11,
        ST_CLOSING = 2'b10
    } gate_state_t;

    localparam int DEF_CAPACITY     = 16;
    localparam int DEF_MOTOR_CYCLES = 50;
    localparam int DEF_OPEN_TIMEOUT = 500;

endpackage

// File: rtl/parking_gate_controller_if.sv
// Entry-gate signal bundle: detector pulses and button in, motor and indicators out.
interface parking_gate_controller_if #(
    parameter int CNT_W = $clog2(parking_pkg::DEF_CAPACITY + 1)
);
    logic             req_entrada;
    logic             entrada;
    logic             salida;
    logic             alarma_clr;
    logic             motor_up;
    logic             motor_down;
    logic             barrera_abierta;
    logic             lleno;
    logic             alarma;
    logic [CNT_W-1:0] ocupacion;
    logic [CNT_W-1:0] libres;

    modport master (
        output req_entrada, entrada, salida, alarma_clr,
        input  motor_up, motor_down, barrera_abierta, lleno, alarma, ocupacion, libres
    );

    modport slave (
        input  req_entrada, entrada, salida, alarma_clr,
        output motor_up, motor_down, barrera_abierta, lleno, alarma, ocupacion, libres
    );
endinterface

// File: rtl/parking_gate_controller_occupancy_counter.sv
// Saturating car count with full/free indicators and a saturation flag.
// Count updates one cycle after inc/dec; no backpressure, pulses are always accepted.
module occupancy_counter #(
    parameter int CAPACITY = parking_pkg::DEF_CAPACITY,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             lleno,
    output logic [CNT_W-1:0] libres,
    output logic             sat_err
);
    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

    logic empty;

    assign lleno  = (count == CAP_V);
    assign empty  = (count == '0);
    assign libres = CAP_V - count;

    // Simultaneous inc and dec cancel out, so they can never saturate.
    assign sat_err = (inc && !dec && lleno) || (dec && !inc && empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !dec && !lleno) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry barrier sequencer plus occupancy count; optional sticky alarm under PARK_ALARM_EN.
// One cycle from request/entry pulse to motor command; no backpressure, inputs always sampled.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = $clog2(CAPACITY + 1),
    parameter int MOTOR_CYCLES = DEF_MOTOR_CYCLES,
    parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT
) (
    input logic                      clk,
    input logic                      reset,
    parking_gate_controller_if.slave bus
);
    localparam int TMR_MAX = (MOTOR_CYCLES > OPEN_TIMEOUT) ? MOTOR_CYCLES : OPEN_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TIMEOUT - 1);

    gate_state_t      state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] libres;
    logic             lleno;
    logic             sat_err;

    occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk     (clk),
        .reset   (reset),
        .inc     (bus.entrada),
        .dec     (bus.salida),
        .count   (count),
        .lleno   (lleno),
        .libres  (libres),
        .sat_err (sat_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CLOSED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // One shared timer: every state change restarts it from zero.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + TMR_W'(1);
        case (state)
            ST_CLOSED: begin
                timer_nxt = '0;
                if (bus.req_entrada && !lleno) begin
                    state_nxt = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (timer == MOTOR_LAST) begin
                    state_nxt = ST_OPEN;
                    timer_nxt = '0;
                end
            end
            ST_OPEN: begin
                if (bus.entrada || (timer == OPEN_LAST)) begin
                    state_nxt = ST_CLOSING;
                    timer_nxt = '0;
                end
            end
            ST_CLOSING: begin
                if (timer == MOTOR_LAST) begin
                    state_nxt = ST_CLOSED;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_CLOSED;
                timer_nxt = '0;
            end
        endcase
    end

    assign bus.motor_up        = (state == ST_OPENING);
    assign bus.motor_down      = (state == ST_CLOSING);
    assign bus.barrera_abierta = (state == ST_OPEN);
    assign bus.lleno           = lleno;
    assign bus.ocupacion       = count;
    assign bus.libres          = libres;

`ifdef PARK_ALARM_EN
    logic alarma_q;
    logic alarm_set;

    // Any car passing without an open barrier, or a count that cannot move.
    assign alarm_set = (bus.entrada && (state != ST_OPEN)) || sat_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarma_q <= 1'b0;
        end else if (alarm_set) begin
            alarma_q <= 1'b1;
        end else if (bus.alarma_clr) begin
            alarma_q <= 1'b0;
        end
    end

    assign bus.alarma = alarma_q;
`else
    logic alarm_unused;
    assign alarm_unused = bus.alarma_clr ^ sat_err;
    assign bus.alarma   = 1'b0;
`endif

endmodule
